coo_adj_fm_wm: RTL and testbench
================================

COO_ADJ_FM_WM -- requirements
Module: coo_adj_fm_wm

Interface
REQ-001 SHALL have parameters: FEATURE_ROWS, default 6, number of graph nodes / rows of FM·WM.
REQ-002 SHALL have parameters: WEIGHT_COLS, default 3, elements per FM·WM row.
REQ-003 SHALL have parameters: DOT_PROD_WIDTH, default 16, element width.
REQ-004 SHALL have parameters: COO_NUM_OF_COLS, default 6, number of non-zero COO entries (NNZ); COO_BW = $clog2(COO_NUM_OF_COLS).
REQ-005 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-006 SHALL have ports: reset  in  1  asynchronous, active-high.
REQ-007 SHALL have ports: done  in  1  start request (upstream FM·WM complete), level.
REQ-008 SHALL have ports: read_fm_wm_address  out  $clog2(FEATURE_ROWS)  row address to external FM·WM memory (combinational-read).
REQ-009 SHALL have ports: fm_wm_row_in  in  WEIGHT_COLS x DOT_PROD_WIDTH  row returned same cycle.
REQ-010 SHALL have ports: coo_address  out  COO_BW  current COO entry index.
REQ-011 SHALL have ports: wr_en  out  1  write strobe to external ADJ result memory.
REQ-012 SHALL have ports: write_address  out  $clog2(FEATURE_ROWS)  destination row.
REQ-013 SHALL have ports: fm_wm_adj_row_out  out  WEIGHT_COLS x DOT_PROD_WIDTH  aggregated row data.
REQ-014 SHALL have ports: ADJ_fm_wm_done  out  1  aggregation complete.

Function
REQ-015 SHALL hold internal COO ROM, 2 x NNZ: entry k = (dest row, src col); default dest = {0,0,1,3,4,4}, src = {1,2,0,5,3,5}; entries sorted by dest.
REQ-016 SHALL compute out[dest] = sum of fm_wm[src] over entries with that dest, per column, modulo 2^DOT_PROD_WIDTH.
REQ-017 SHALL implement FSM IDLE, ACC, WRITE, FIN.
REQ-018 SHALL in IDLE: coo_address=0, acc=0; done=1 -> ACC next cycle.
REQ-019 SHALL in ACC: read_fm_wm_address = src[coo_address]; acc += fm_wm_row_in; if coo_address=NNZ-1 or dest[coo_address+1] != dest[coo_address] -> WRITE, else coo_address+1, stay ACC.
REQ-020 SHALL in WRITE: wr_en=1 for exactly one cycle, write_address=dest[coo_address], fm_wm_adj_row_out=acc; then acc cleared; if last entry -> FIN else coo_address+1 -> ACC.
REQ-021 SHALL in FIN: ADJ_fm_wm_done=1, held while done=1; done=0 -> IDLE, flag clears.
REQ-022 SHALL not write rows absent from COO dest (external memory supplies zero from its reset).
REQ-023 SHALL, for unsorted dest runs, write each run separately (last write wins); no read-modify-write.
REQ-024 SHALL drive wr_en=0 and fm_wm_adj_row_out=0 outside WRITE.
REQ-025 SHALL ignore done changes while in ACC/WRITE (run completes).

Reset
REQ-026 SHALL on reset assertion immediately: state=IDLE, coo_address=0, acc=0, wr_en=0, ADJ_fm_wm_done=0, write_address=0, read_fm_wm_address=0.
REQ-027 SHALL, on reset mid-run, abort with no further writes; restart needs done after release.

Configuration
REQ-028 SHALL support macro ACC_SATURATE_EN: defined -> per-column accumulation saturates at 2^DOT_PROD_WIDTH-1; undefined -> wraps modulo 2^DOT_PROD_WIDTH.

Verification
REQ-029 SHALL cover: FM·WM row i = {i,i,i}, done=1 -> writes row0={3,3,3}, row1={0,0,0}, row3={5,5,5}, row4={8,8,8}, in that order; rows 2,5 never written.
REQ-030 SHALL cover: same stimulus -> exactly 4 wr_en pulses, ADJ_fm_wm_done high at cycle 11 after done rises (6 ACC + 4 WRITE).
REQ-031 SHALL cover: reset asserted during second ACC -> outputs zero immediately, no write; re-run after release gives REQ-029 results.
REQ-032 SHALL cover: fm_wm rows 3,5 = 0xFFFF -> row4 = 0xFFFE without ACC_SATURATE_EN, 0xFFFF with it.
REQ-033 SHALL cover: done held low -> no wr_en, ADJ_fm_wm_done=0; done dropped in FIN -> IDLE, done flag clears next cycle.

Source files
------------

// File: rtl/coo_adj_fm_wm.sv
// rtl/coo_adj_fm_wm.sv - COO-driven aggregation of FM*WM rows into ADJ*FM*WM rows.
// Optional macro ACC_SATURATE_EN: per-column accumulation saturates instead of wrapping.
module coo_adj_fm_wm #(
    parameter int FEATURE_ROWS    = 6,
    parameter int WEIGHT_COLS     = 3,
    parameter int DOT_PROD_WIDTH  = 16,
    parameter int COO_NUM_OF_COLS = 6,
    localparam int COO_BW = (COO_NUM_OF_COLS > 1) ? $clog2(COO_NUM_OF_COLS) : 1,
    localparam int AW     = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1,
    localparam int ROW_W  = WEIGHT_COLS * DOT_PROD_WIDTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              done,
    output logic [AW-1:0]     read_fm_wm_address,
    input  logic [ROW_W-1:0]  fm_wm_row_in,
    output logic [COO_BW-1:0] coo_address,
    output logic              wr_en,
    output logic [AW-1:0]     write_address,
    output logic [ROW_W-1:0]  fm_wm_adj_row_out,
    output logic              ADJ_fm_wm_done
);

    typedef enum logic [1:0] {IDLE, ACC, WRITE, FIN} state_t;

    // COO table, sorted by destination row; entries past the table read as row 0.
    localparam int ROM_N = 6;
    localparam int DEST_ROM [ROM_N] = '{0, 0, 1, 3, 4, 4};
    localparam int SRC_ROM  [ROM_N] = '{1, 2, 0, 5, 3, 5};
    localparam logic [COO_BW-1:0] LAST_IDX = COO_BW'(COO_NUM_OF_COLS - 1);

    function automatic logic [AW-1:0] coo_dest(input logic [COO_BW-1:0] k);
        coo_dest = '0;
        if (int'(k) < ROM_N) coo_dest = AW'(DEST_ROM[int'(k)]);
    endfunction

    function automatic logic [AW-1:0] coo_src(input logic [COO_BW-1:0] k);
        coo_src = '0;
        if (int'(k) < ROM_N) coo_src = AW'(SRC_ROM[int'(k)]);
    endfunction

    state_t              state_q;
    logic [COO_BW-1:0]   coo_q;
    logic [ROW_W-1:0]    acc_q;
    logic                wr_en_q;
    logic [AW-1:0]       waddr_q;
    logic [ROW_W-1:0]    out_q;
    logic                fin_q;

    logic [ROW_W-1:0]    acc_d;
    logic [DOT_PROD_WIDTH:0] col_sum;
    logic                last_entry;
    logic                run_end;

    always_comb begin
        acc_d   = '0;
        col_sum = '0;
        for (int c = 0; c < WEIGHT_COLS; c++) begin
            col_sum = {1'b0, acc_q[c*DOT_PROD_WIDTH +: DOT_PROD_WIDTH]}
                    + {1'b0, fm_wm_row_in[c*DOT_PROD_WIDTH +: DOT_PROD_WIDTH]};
`ifdef ACC_SATURATE_EN
            if (col_sum[DOT_PROD_WIDTH]) col_sum[DOT_PROD_WIDTH-1:0] = '1;
`endif
            acc_d[c*DOT_PROD_WIDTH +: DOT_PROD_WIDTH] = col_sum[DOT_PROD_WIDTH-1:0];
        end
    end

    // A run of equal destinations ends at the table end or where the next entry's row differs.
    assign last_entry = (coo_q == LAST_IDX);
    assign run_end    = last_entry || (coo_dest(coo_q + 1'b1) != coo_dest(coo_q));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            coo_q   <= '0;
            acc_q   <= '0;
            wr_en_q <= 1'b0;
            waddr_q <= '0;
            out_q   <= '0;
            fin_q   <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            waddr_q <= '0;
            out_q   <= '0;
            case (state_q)
                IDLE: begin
                    coo_q <= '0;
                    acc_q <= '0;
                    fin_q <= 1'b0;
                    if (done) state_q <= ACC;
                end
                ACC: begin
                    acc_q <= acc_d;
                    if (run_end) begin
                        state_q <= WRITE;
                        wr_en_q <= 1'b1;
                        waddr_q <= coo_dest(coo_q);
                        out_q   <= acc_d;
                    end else begin
                        coo_q <= coo_q + 1'b1;
                    end
                end
                WRITE: begin
                    acc_q <= '0;
                    if (last_entry) begin
                        state_q <= FIN;
                        fin_q   <= 1'b1;
                    end else begin
                        coo_q   <= coo_q + 1'b1;
                        state_q <= ACC;
                    end
                end
                FIN: begin
                    if (!done) begin
                        state_q <= IDLE;
                        fin_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign read_fm_wm_address = (state_q == ACC) ? coo_src(coo_q) : '0;
    assign coo_address        = coo_q;
    assign wr_en              = wr_en_q;
    assign write_address      = waddr_q;
    assign fm_wm_adj_row_out  = out_q;
    assign ADJ_fm_wm_done     = fin_q;

endmodule

// File: tb/tb_coo_adj_fm_wm.sv
// tb/tb_coo_adj_fm_wm.sv - directed-vector bench for coo_adj_fm_wm.
module tb_coo_adj_fm_wm;

    logic        clk = 1'b0;
    logic        reset;
    logic        done;
    logic [2:0]  read_fm_wm_address;
    logic [47:0] fm_wm_row_in;
    logic [2:0]  coo_address;
    logic        wr_en;
    logic [2:0]  write_address;
    logic [47:0] fm_wm_adj_row_out;
    logic        ADJ_fm_wm_done;

    logic [47:0] fm_mem [8];
    int          n_vec = 0;
    int          n_mis = 0;
    logic [2:0]  wa [8];
    logic [47:0] wd [8];

    always #5 clk = ~clk;

    assign fm_wm_row_in = fm_mem[read_fm_wm_address];

    coo_adj_fm_wm dut (
        .clk                (clk),
        .reset              (reset),
        .done               (done),
        .read_fm_wm_address (read_fm_wm_address),
        .fm_wm_row_in       (fm_wm_row_in),
        .coo_address        (coo_address),
        .wr_en              (wr_en),
        .write_address      (write_address),
        .fm_wm_adj_row_out  (fm_wm_adj_row_out),
        .ADJ_fm_wm_done     (ADJ_fm_wm_done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] rowv(input logic [15:0] v);
        return {v, v, v};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Raises done and steps edge by edge, capturing writes until the completion flag appears.
    task automatic run_job(output int nw, output int done_cyc);
        nw = 0;
        done_cyc = -1;
        done = 1'b1;
        for (int n = 1; n <= 40; n++) begin
            step();
            if (wr_en) begin
                if (nw < 8) begin
                    wa[nw] = write_address;
                    wd[nw] = fm_wm_adj_row_out;
                end
                nw++;
            end
            if (ADJ_fm_wm_done) begin
                done_cyc = n;
                break;
            end
        end
    endtask

    task automatic check_job(input string tag, input logic [47:0] r0, input logic [47:0] r1,
                             input logic [47:0] r3, input logic [47:0] r4);
        int nw, dc;
        logic [2:0]  ea [4];
        logic [47:0] ed [4];
        ea = '{3'd0, 3'd1, 3'd3, 3'd4};
        ed = '{r0, r1, r3, r4};
        run_job(nw, dc);
        check({tag, "_nwrites"}, 64'(nw), 64'd4);
        check({tag, "_done_cycle"}, 64'(dc), 64'd11);
        for (int i = 0; i < 4; i++) begin
            if (i < nw) begin
                check($sformatf("%s_addr%0d", tag, i), 64'(wa[i]), 64'(ea[i]));
                check($sformatf("%s_data%0d", tag, i), 64'(wd[i]), 64'(ed[i]));
            end
        end
    endtask

    initial begin
        int cnt;
        for (int i = 0; i < 8; i++) fm_mem[i] = (i < 6) ? rowv(16'(i)) : 48'h0;
        reset = 1'b1;
        done  = 1'b0;
        step();
        step();
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_done_flag", 64'(ADJ_fm_wm_done), 64'd0);
        check("rst_coo_addr", 64'(coo_address), 64'd0);
        check("rst_rd_addr", 64'(read_fm_wm_address), 64'd0);
        check("rst_wr_addr", 64'(write_address), 64'd0);
        check("rst_row_out", 64'(fm_wm_adj_row_out), 64'd0);
        reset = 1'b0;

        cnt = 0;
        for (int n = 0; n < 20; n++) begin
            step();
            if (wr_en) cnt++;
            if (ADJ_fm_wm_done) cnt += 100;
        end
        check("idle_no_activity", 64'(cnt), 64'd0);

        check_job("run1", rowv(16'd3), rowv(16'd0), rowv(16'd5), rowv(16'd8));
        cnt = 0;
        for (int n = 0; n < 3; n++) begin
            step();
            if (ADJ_fm_wm_done) cnt++;
            if (wr_en) cnt += 100;
        end
        check("fin_hold", 64'(cnt), 64'd3);
        done = 1'b0;
        step();
        check("fin_release", 64'(ADJ_fm_wm_done), 64'd0);
        step();
        check("idle_after_fin_coo", 64'(coo_address), 64'd0);

        done = 1'b1;
        step();
        check("acc0_rd_addr", 64'(read_fm_wm_address), 64'd1);
        step();
        check("acc1_rd_addr", 64'(read_fm_wm_address), 64'd2);
        check("acc1_coo_addr", 64'(coo_address), 64'd1);
        reset = 1'b1;
        #1;
        check("midrst_rd_addr", 64'(read_fm_wm_address), 64'd0);
        check("midrst_coo_addr", 64'(coo_address), 64'd0);
        check("midrst_wr_en", 64'(wr_en), 64'd0);
        check("midrst_row_out", 64'(fm_wm_adj_row_out), 64'd0);
        done = 1'b0;
        cnt = 0;
        for (int n = 0; n < 2; n++) begin
            step();
            if (wr_en) cnt++;
        end
        reset = 1'b0;
        for (int n = 0; n < 4; n++) begin
            step();
            if (wr_en) cnt++;
        end
        check("midrst_no_write", 64'(cnt), 64'd0);
        check_job("rerun", rowv(16'd3), rowv(16'd0), rowv(16'd5), rowv(16'd8));
        done = 1'b0;
        step();
        step();

        fm_mem[3] = rowv(16'hFFFF);
        fm_mem[5] = rowv(16'hFFFF);
`ifdef ACC_SATURATE_EN
        check_job("ovf", rowv(16'd3), rowv(16'd0), rowv(16'hFFFF), rowv(16'hFFFF));
`else
        check_job("ovf", rowv(16'd3), rowv(16'd0), rowv(16'hFFFF), rowv(16'hFFFE));
`endif
        done = 1'b0;
        step();
        check("ovf_release", 64'(ADJ_fm_wm_done), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
